fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the single write port of one FIFO instance among NUM_REQ requesters in the FIFO write clock domain. Each requester offers beats on a valid/ready handshake with an optional last marker. The arbiter grants one requester at a time for a bounded burst, steers its data onto the FIFO write port, and back-pressures on the FIFO `full` flag. It also keeps per-requester accepted-beat counters for debug.

---
 rtl/fifo_wr_arbiter.sv | 139 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_wr_arbiter
// Purpose  : Round-robin arbiter sharing one FIFO write port among NUM_REQ
//            valid/ready requesters, with bounded bursts and debug counters.
// Revision : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4,
    parameter int CNT_WIDTH = 16,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*WIDTH-1:0]     req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         fifo_full,
    output logic                         fifo_w_en,
    output logic [WIDTH-1:0]             fifo_data,
    output logic                         grant_valid,
    output logic [ID_W-1:0]              grant_id,
    output logic [NUM_REQ*CNT_WIDTH-1:0] beat_cnt
);

    localparam int                 c_BC_W      = $clog2(MAX_BURST + 1);
    localparam logic [0:0]         c_IDLE      = 1'b0;
    localparam logic [0:0]         c_GRANT     = 1'b1;
    localparam logic [ID_W-1:0]    c_LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [c_BC_W-1:0]  c_BURST_END = c_BC_W'(MAX_BURST - 1);

    logic [0:0]         r_state,      w_state_nxt;
    logic [ID_W-1:0]    r_rr_ptr,     w_rr_ptr_nxt;
    logic [ID_W-1:0]    r_grant_id,   w_grant_id_nxt;
    logic [c_BC_W-1:0]  r_burst_ctr,  w_burst_ctr_nxt;
    logic [CNT_WIDTH-1:0] r_beat_cnt [NUM_REQ];

    logic            w_any;
    logic [ID_W-1:0] w_sel;
    logic            w_g_valid;
    logic            w_g_last;
    logic            w_acc;

    // Walk downward so the smallest offset from rr_ptr is the last to win.
    always_comb begin
        w_any = 1'b0;
        w_sel = r_rr_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req_valid[ID_W'((int'(r_rr_ptr) + k) % NUM_REQ)]) begin
                w_any = 1'b1;
                w_sel = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        w_g_valid = 1'b0;
        w_g_last  = 1'b0;
        fifo_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant_id == ID_W'(i)) begin
                w_g_valid = req_valid[i];
                w_g_last  = req_last[i];
                fifo_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_grant_id_nxt  = r_grant_id;
        w_burst_ctr_nxt = r_burst_ctr;
        w_acc           = 1'b0;
        req_ready       = '0;
        fifo_w_en       = 1'b0;
        grant_valid     = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (w_any) begin
                    w_state_nxt     = c_GRANT;
                    w_grant_id_nxt  = w_sel;
                    w_burst_ctr_nxt = '0;
                end
            end
            c_GRANT: begin
                grant_valid = 1'b1;
                w_acc       = w_g_valid & ~fifo_full;
                fifo_w_en   = w_acc;
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = (r_grant_id == ID_W'(i)) & ~fifo_full;
                end
                if (w_acc) begin
                    w_burst_ctr_nxt = r_burst_ctr + c_BC_W'(1);
                end
                // A stalled beat (full with valid high) never releases.
                if ((w_acc && (w_g_last || r_burst_ctr == c_BURST_END)) || !w_g_valid) begin
                    w_state_nxt  = c_IDLE;
                    w_rr_ptr_nxt = (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + ID_W'(1);
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_burst_ctr <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_burst_ctr <= w_burst_ctr_nxt;
        end
    end

    assign grant_id = r_grant_id;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_beat_cnt[i] <= '0;
                end else if (w_acc && r_grant_id == ID_W'(i) && r_beat_cnt[i] != '1) begin
                    r_beat_cnt[i] <= r_beat_cnt[i] + CNT_WIDTH'(1);
                end
            end
            assign beat_cnt[i*CNT_WIDTH +: CNT_WIDTH] = r_beat_cnt[i];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Purpose  : Self-checking bench for fifo_wr_arbiter against a behavioural
//            round-robin model (NUM_REQ=4, MAX_BURST=4, CNT_WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 8;
    localparam int MAX_BURST = 4;
    localparam int CNT_WIDTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [3:0]  req_last  = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_ready;
    logic        fifo_full = 1'b0;
    logic        fifo_w_en;
    logic [7:0]  fifo_data;
    logic        grant_valid;
    logic [1:0]  grant_id;
    logic [15:0] beat_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural model state
    int m_busy, m_g, m_burst, m_rr;
    int m_cnt [NUM_REQ];

    fifo_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .WIDTH    (WIDTH),
        .MAX_BURST(MAX_BURST),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_last   (req_last),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .fifo_full  (fifo_full),
        .fifo_w_en  (fifo_w_en),
        .fifo_data  (fifo_data),
        .grant_valid(grant_valid),
        .grant_id   (grant_id),
        .beat_cnt   (beat_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic exp_wen();
        return (m_busy != 0) && req_valid[m_g] && !fifo_full && !rst;
    endfunction

    function automatic logic [3:0] exp_ready();
        logic [3:0] r;
        r = '0;
        if (m_busy != 0 && !fifo_full) r[m_g] = 1'b1;
        return r;
    endfunction

    function automatic logic [7:0] exp_data();
        return req_data[m_g*8 +: 8];
    endfunction

    function automatic logic [15:0] exp_bc();
        logic [15:0] r;
        for (int i = 0; i < NUM_REQ; i++) r[i*4 +: 4] = 4'(m_cnt[i]);
        return r;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_g = 0; m_burst = 0; m_rr = 0;
        for (int i = 0; i < NUM_REQ; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step();
        logic acc;
        int   found;
        if (rst) begin
            model_reset();
        end else if (m_busy == 0) begin
            found = 0;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (found == 0 && req_valid[(m_rr + k) % NUM_REQ]) begin
                    found = 1;
                    m_g   = (m_rr + k) % NUM_REQ;
                end
            end
            if (found != 0) begin
                m_busy  = 1;
                m_burst = 0;
            end
        end else begin
            acc = exp_wen();
            if ((acc && (req_last[m_g] || m_burst == MAX_BURST - 1)) || !req_valid[m_g]) begin
                m_busy = 0;
                m_rr   = (m_g + 1) % NUM_REQ;
            end
            if (acc) begin
                m_burst++;
                if (m_cnt[m_g] < 15) m_cnt[m_g]++;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req_valid = '0; req_last = '0; fifo_full = 1'b0;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req_valid = 4'hF; req_data = $urandom; fifo_full = 1'b0;
        model_reset();
        tick();
        tick();
        #1;
        n_chk++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_gv: got %0h want 0", grant_valid); end
        n_chk++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_gid: got %0h want 0", grant_id); end
        n_chk++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready: got %0h want 0", req_ready); end
        n_chk++; if (fifo_w_en !== 1'b0) begin n_fail++; $display("FAIL reset_wen: got %0h want 0", fifo_w_en); end
        n_chk++; if (beat_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_bc: got %0h want 0", beat_cnt); end
        n_chk++; if (fifo_data !== req_data[7:0]) begin n_fail++; $display("FAIL reset_data: got %0h want %0h", fifo_data, req_data[7:0]); end
        @(negedge clk);
        rst = 1'b0; req_valid = '0;
    endtask

    task automatic test_single();
        int k;
        logic [11:0] pattern;
        do_reset();
        k = 0; pattern = '0;
        for (int c = 0; c < 12; c++) begin
            req_valid = (k < 6) ? 4'b0100 : 4'b0000;
            req_last  = '0;
            req_data  = 32'(8'h10 + k) << 16;
            #1;
            n_chk++; if (fifo_w_en !== exp_wen()) begin n_fail++; $display("FAIL single_wen c%0d: got %0h want %0h", c, fifo_w_en, exp_wen()); end
            pattern[c] = fifo_w_en;
            if (fifo_w_en === 1'b1) begin
                n_chk++; if (fifo_data !== 8'(8'h10 + k)) begin n_fail++; $display("FAIL single_data: got %0h want %0h", fifo_data, 8'(8'h10 + k)); end
                k++;
            end
            tick();
        end
        n_chk++; if (pattern !== 12'b0000_1101_1110) begin n_fail++; $display("FAIL single_pattern: got %b want 000011011110", pattern); end
        n_chk++; if (k != 6) begin n_fail++; $display("FAIL single_beats: got %0d want 6", k); end
        n_chk++; if (beat_cnt[11:8] !== 4'd6) begin n_fail++; $display("FAIL single_bc2: got %0d want 6", beat_cnt[11:8]); end
    endtask

    task automatic test_fairness();
        int nw;
        do_reset();
        req_valid = 4'hF; req_last = 4'hF; nw = 0;
        for (int c = 0; c < 16; c++) begin
            req_data = $urandom;
            #1;
            n_chk++; if (fifo_w_en !== exp_wen()) begin n_fail++; $display("FAIL fair_wen c%0d: got %0h want %0h", c, fifo_w_en, exp_wen()); end
            if (fifo_w_en === 1'b1) begin
                n_chk++; if (grant_id !== 2'(nw % 4)) begin n_fail++; $display("FAIL fair_gid: got %0d want %0d", grant_id, nw % 4); end
                n_chk++; if (fifo_data !== exp_data()) begin n_fail++; $display("FAIL fair_data: got %0h want %0h", fifo_data, exp_data()); end
                nw++;
            end
            tick();
        end
        n_chk++; if (nw != 8) begin n_fail++; $display("FAIL fair_duty: got %0d writes want 8", nw); end
    endtask

    task automatic test_full_stall();
        int b;
        do_reset();
        req_valid = 4'b1000; req_last = '0; b = 0;
        for (int c = 0; c < 11; c++) begin
            fifo_full = (c >= 2 && c <= 6);
            req_data  = 32'(8'hA0 + b) << 24;
            #1;
            if (c >= 2 && c <= 6) begin
                n_chk++; if (fifo_w_en !== 1'b0) begin n_fail++; $display("FAIL stall_wen c%0d: got %0h want 0", c, fifo_w_en); end
                n_chk++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL stall_ready c%0d: got %0h want 0", c, req_ready); end
                n_chk++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL stall_gv c%0d: got %0h want 1", c, grant_valid); end
            end
            if (c == 7) begin
                n_chk++; if (fifo_w_en !== 1'b1 || fifo_data !== 8'hA1) begin n_fail++; $display("FAIL stall_resume: got wen=%0h data=%0h want 1/a1", fifo_w_en, fifo_data); end
                n_chk++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL stall_ready_resume: got %0h want 8", req_ready); end
            end
            if (c == 9) begin
                n_chk++; if (fifo_w_en !== 1'b1 || fifo_data !== 8'hA3) begin n_fail++; $display("FAIL stall_last_beat: got wen=%0h data=%0h want 1/a3", fifo_w_en, fifo_data); end
            end
            if (c == 10) begin
                n_chk++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL stall_burst_end: got gv=%0h want 0", grant_valid); end
            end
            if (fifo_w_en === 1'b1) b++;
            tick();
        end
        fifo_full = 1'b0;
    endtask

    task automatic test_early_release();
        do_reset();
        for (int c = 0; c < 9; c++) begin
            req_valid = (c < 3) ? 4'b0010 : 4'b1001;
            req_last  = (c < 3) ? 4'b0000 : 4'b1001;
            req_data  = $urandom;
            #1;
            if (c == 1 || c == 2) begin
                n_chk++; if (fifo_w_en !== 1'b1) begin n_fail++; $display("FAIL early_beat c%0d: got %0h want 1", c, fifo_w_en); end
            end
            if (c == 3) begin
                n_chk++; if (grant_valid !== 1'b1 || grant_id !== 2'd1 || fifo_w_en !== 1'b0) begin n_fail++; $display("FAIL early_drop: got gv=%0h gid=%0h wen=%0h want 1/1/0", grant_valid, grant_id, fifo_w_en); end
            end
            if (c == 4) begin
                n_chk++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL early_idle: got %0h want 0", grant_valid); end
            end
            if (c == 5) begin
                n_chk++; if (grant_valid !== 1'b1 || grant_id !== 2'd3) begin n_fail++; $display("FAIL early_next: got gv=%0h gid=%0h want 1/3", grant_valid, grant_id); end
            end
            if (c == 7) begin
                n_chk++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin n_fail++; $display("FAIL early_wrap: got gv=%0h gid=%0h want 1/0", grant_valid, grant_id); end
            end
            tick();
        end
    endtask

    task automatic test_saturation();
        int nw;
        do_reset();
        req_last = '0; nw = 0;
        for (int c = 0; c < 40; c++) begin
            req_valid = (nw < 20) ? 4'b0001 : 4'b0000;
            req_data  = $urandom;
            #1;
            n_chk++; if (beat_cnt !== exp_bc()) begin n_fail++; $display("FAIL sat_bc c%0d: got %0h want %0h", c, beat_cnt, exp_bc()); end
            if (fifo_w_en === 1'b1) nw++;
            tick();
        end
        n_chk++; if (nw != 20) begin n_fail++; $display("FAIL sat_writes: got %0d want 20", nw); end
        n_chk++; if (beat_cnt[3:0] !== 4'hF) begin n_fail++; $display("FAIL sat_value: got %0h want f", beat_cnt[3:0]); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_valid = 4'b0010; req_last = 4'b0010; req_data = $urandom;
        tick();                          // IDLE, picks 1
        tick();                          // 1-beat packet, rr moves to 2
        req_valid = 4'b0100; req_last = '0;
        tick();                          // IDLE, picks 2
        tick();                          // beat 1
        #1;
        n_chk++; if (fifo_w_en !== 1'b1 || grant_id !== 2'd2) begin n_fail++; $display("FAIL mid_pre: got wen=%0h gid=%0h want 1/2", fifo_w_en, grant_id); end
        n_chk++; if (beat_cnt !== 16'h0110) begin n_fail++; $display("FAIL mid_pre_bc: got %0h want 0110", beat_cnt); end
        rst = 1'b1;
        #1;
        n_chk++; if (grant_valid !== 1'b0 || fifo_w_en !== 1'b0 || req_ready !== 4'h0) begin n_fail++; $display("FAIL mid_rst_out: got gv=%0h wen=%0h rdy=%0h want 0/0/0", grant_valid, fifo_w_en, req_ready); end
        n_chk++; if (beat_cnt !== 16'h0) begin n_fail++; $display("FAIL mid_rst_bc: got %0h want 0", beat_cnt); end
        tick();
        n_chk++; if (beat_cnt !== 16'h0) begin n_fail++; $display("FAIL mid_rst_nowrite: got %0h want 0", beat_cnt); end
        rst = 1'b0; req_valid = 4'hF; req_last = '0;
        #1;
        n_chk++; if (grant_valid !== 1'b0 || grant_id !== 2'd0) begin n_fail++; $display("FAIL mid_after_idle: got gv=%0h gid=%0h want 0/0", grant_valid, grant_id); end
        tick();
        #1;
        n_chk++; if (grant_valid !== 1'b1 || grant_id !== 2'd0) begin n_fail++; $display("FAIL mid_first_grant: got gv=%0h gid=%0h want 1/0", grant_valid, grant_id); end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            req_valid = 4'($urandom);
            req_last  = 4'($urandom);
            req_data  = $urandom;
            fifo_full = ($urandom % 4 == 0);
            #1;
            n_chk++; if (grant_valid !== (m_busy != 0)) begin n_fail++; $display("FAIL rnd_gv c%0d: got %0h want %0h", c, grant_valid, m_busy); end
            n_chk++; if (grant_id !== 2'(m_g)) begin n_fail++; $display("FAIL rnd_gid c%0d: got %0h want %0h", c, grant_id, m_g); end
            n_chk++; if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready c%0d: got %0h want %0h", c, req_ready, exp_ready()); end
            n_chk++; if (fifo_w_en !== exp_wen()) begin n_fail++; $display("FAIL rnd_wen c%0d: got %0h want %0h", c, fifo_w_en, exp_wen()); end
            n_chk++; if (fifo_data !== exp_data()) begin n_fail++; $display("FAIL rnd_data c%0d: got %0h want %0h", c, fifo_data, exp_data()); end
            n_chk++; if (beat_cnt !== exp_bc()) begin n_fail++; $display("FAIL rnd_bc c%0d: got %0h want %0h", c, beat_cnt, exp_bc()); end
            tick();
        end
        fifo_full = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_fairness();
        test_full_stall();
        test_early_release();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
